// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: pixel-clock divider, h/v timing counters and a
// registered pattern generator whose mode/colour are latched once per frame.
module vga_pattern_gen #(
   parameter int CW      = 1,
   parameter int CLK_DIV = 4,
   parameter int H_DISP  = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_DISP  = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      mode,
   input  logic [3*CW-1:0] color,
   output logic            hsync,
   output logic            vsync,
   output logic            video_on,
   output logic [9:0]      pixel_x,
   output logic [9:0]      pixel_y,
   output logic [3*CW-1:0] rgb,
   output logic            frame_start
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_DISP);
   localparam logic [9:0] V_ACT    = 10'(V_DISP);
   localparam logic [9:0] HS_BEG   = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);
   localparam logic [9:0] BAR_LAST = 10'(H_DISP / 8 - 1);

   logic [DW-1:0]   div;
   logic            tick;
   logic            frame_tick;
   logic            active;
   logic [9:0]      h_cnt;
   logic [9:0]      v_cnt;
   logic [9:0]      bar_cnt;
   logic [2:0]      bar_idx;
   logic [1:0]      shadow_mode;
   logic [1:0]      eff_mode;
   logic [3*CW-1:0] shadow_color;
   logic [3*CW-1:0] eff_color;
   logic [3*CW-1:0] pattern;

   assign tick       = (div == DIV_LAST);
   assign frame_tick = tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);

   // Pixel (0,0) is rendered on the sampling tick itself, so it bypasses the shadow.
   assign eff_mode  = frame_tick ? mode : shadow_mode;
   assign eff_color = frame_tick ? color : shadow_color;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Bar index tracks h_cnt / (H_DISP/8) with a sub-counter instead of a divider.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bar_cnt <= 10'd0;
         bar_idx <= 3'd0;
      end else if (tick) begin
         if (h_cnt == H_LAST) begin
            bar_cnt <= 10'd0;
            bar_idx <= 3'd0;
         end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= 10'd0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_cnt <= bar_cnt + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_mode  <= 2'd0;
         shadow_color <= '0;
         frame_start  <= 1'b0;
      end else begin
         frame_start <= frame_tick;
         if (frame_tick) begin
            shadow_mode  <= mode;
            shadow_color <= color;
         end
      end
   end

   always_comb begin
      pattern = '0;
      case (eff_mode)
         2'd0:    pattern = eff_color;
         2'd1:    pattern = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
         2'd2:    pattern = (h_cnt[5] ^ v_cnt[5]) ? ~eff_color : eff_color;
         default: pattern = {3{h_cnt[9 -: CW]}};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_x  <= 10'd0;
         pixel_y  <= 10'd0;
         video_on <= 1'b0;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         rgb      <= '0;
      end else if (tick) begin
         pixel_x  <= h_cnt;
         pixel_y  <= v_cnt;
         video_on <= active;
         hsync    <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
         vsync    <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
         rgb      <= active ? pattern : '0;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken raster: hand-written pixel vectors
// plus a per-clock comparison against a pixel-index arithmetic model.
module tb_vga_pattern_gen;

   localparam int CW      = 4;
   localparam int CLK_DIV = 2;
   localparam int H_DISP  = 256;
   localparam int H_FP    = 8;
   localparam int H_SYNC  = 16;
   localparam int H_BP    = 8;
   localparam int V_DISP  = 40;
   localparam int V_FP    = 2;
   localparam int V_SYNC  = 3;
   localparam int V_BP    = 3;
   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int FRAME   = H_TOTAL * V_TOTAL;
   localparam int RW      = 3 * CW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [RW-1:0] color = '0;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [9:0]    pixel_x;
   logic [9:0]    pixel_y;
   logic [RW-1:0] rgb;
   logic          frame_start;

   always #5 clk = ~clk;

   vga_pattern_gen #(
      .CW(CW), .CLK_DIV(CLK_DIV),
      .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .color(color),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb(rgb), .frame_start(frame_start)
   );

   typedef struct {
      int            mode;
      logic [RW-1:0] color;
      int            x;
      int            y;
      logic [RW-1:0] rgb;
      logic          hs;
      logic          vs;
      logic          von;
   } vec_t;

   vec_t vecs[$];

   int            checks = 0;
   int            errors = 0;
   int            clk_cnt;
   int            tick_cnt;
   int            sh_mode;
   logic [RW-1:0] sh_color;
   logic          exp_hs, exp_vs, exp_von, exp_fs;
   logic [9:0]    exp_x, exp_y;
   logic [RW-1:0] exp_rgb;
   logic          rnd_on = 1'b0;

   function automatic void add_vec(int m, logic [RW-1:0] c, int x, int y,
                                   logic [RW-1:0] p, logic hs, logic vs, logic von);
      vec_t v;
      v.mode = m; v.color = c; v.x = x; v.y = y;
      v.rgb = p; v.hs = hs; v.vs = vs; v.von = von;
      vecs.push_back(v);
   endfunction

   function automatic logic [RW-1:0] pattern_of(int m, logic [RW-1:0] c, int x, int y);
      int ones = (1 << CW) - 1;
      int i;
      int g;
      case (m)
         0: return c;
         1: begin
            i = x / (H_DISP / 8);
            return RW'(((((i >> 2) & 1) * ones) << (2 * CW)) |
                       ((((i >> 1) & 1) * ones) << CW) | ((i & 1) * ones));
         end
         2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? ~c : c;
         default: begin
            g = (x >> (10 - CW)) & ones;
            return RW'((g << (2 * CW)) | (g << CW) | g);
         end
      endcase
   endfunction

   task automatic model_reset();
      clk_cnt = 0; tick_cnt = 0; sh_mode = 0; sh_color = '0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_von = 1'b0; exp_fs = 1'b0;
      exp_x = 10'd0; exp_y = 10'd0; exp_rgb = '0;
   endtask

   // Each tick shows pixel number tick_cnt of an endless raster scan.
   task automatic model_edge();
      int p, x, y;
      clk_cnt++;
      exp_fs = 1'b0;
      if (clk_cnt % CLK_DIV == 0) begin
         p = tick_cnt % FRAME;
         x = p % H_TOTAL;
         y = p / H_TOTAL;
         if (p == 0) begin
            sh_mode  = int'(mode);
            sh_color = color;
            exp_fs   = 1'b1;
         end
         exp_x   = 10'(x);
         exp_y   = 10'(y);
         exp_von = (x < H_DISP) && (y < V_DISP);
         exp_hs  = !((x >= H_DISP + H_FP) && (x < H_DISP + H_FP + H_SYNC));
         exp_vs  = !((y >= V_DISP + V_FP) && (y < V_DISP + V_FP + V_SYNC));
         exp_rgb = exp_von ? pattern_of(sh_mode, sh_color, x, y) : '0;
         tick_cnt++;
      end
   endtask

   task automatic check_val(string name, logic [63:0] actual, logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic check_output();
      check_val("model outputs",
                64'({frame_start, video_on, hsync, vsync, pixel_x, pixel_y, rgb}),
                64'({exp_fs, exp_von, exp_hs, exp_vs, exp_x, exp_y, exp_rgb}));
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
      check_output();
      if (rnd_on && $urandom_range(0, 199) == 0) begin
         mode  = 2'($urandom);
         color = RW'($urandom);
      end
   endtask

   task automatic run_to(int target);
      int guard = 0;
      while (tick_cnt < target + 1 && guard < 4 * CLK_DIV * FRAME) begin
         step();
         guard++;
      end
      if (tick_cnt != target + 1) begin
         checks++;
         errors++;
         $display("[TB] FAIL run_to: reached tick %0d, wanted %0d", tick_cnt, target + 1);
      end
   endtask

   task automatic apply_stimulus(int m, logic [RW-1:0] c, int hold);
      reset = 1'b1;
      model_reset();
      mode  = 2'(m);
      color = c;
      #1;
      check_val("reset outputs",
                64'({frame_start, video_on, hsync, vsync, pixel_x, pixel_y, rgb}),
                64'({1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000}));
      repeat (hold) begin
         @(negedge clk);
         check_output();
      end
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int target;
      int cur_mode;
      logic [RW-1:0] cur_color;
      logic [RW-1:0] solid;

      add_vec(0, 12'hA5C,   0, 0, 12'hA5C, 1, 1, 1);
      add_vec(0, 12'hA5C, 255, 0, 12'hA5C, 1, 1, 1);
      add_vec(0, 12'hA5C, 256, 0, 12'h000, 1, 1, 0);
      add_vec(0, 12'hA5C, 264, 0, 12'h000, 0, 1, 0);
      add_vec(0, 12'hA5C, 279, 0, 12'h000, 0, 1, 0);
      add_vec(0, 12'hA5C, 280, 0, 12'h000, 1, 1, 0);
      add_vec(0, 12'hA5C,  10, 1, 12'hA5C, 1, 1, 1);
      add_vec(1, 12'h000,   0, 0, 12'h000, 1, 1, 1);
      add_vec(1, 12'h000,  31, 0, 12'h000, 1, 1, 1);
      add_vec(1, 12'h000,  32, 0, 12'h00F, 1, 1, 1);
      add_vec(1, 12'h000,  64, 0, 12'h0F0, 1, 1, 1);
      add_vec(1, 12'h000,  96, 0, 12'h0FF, 1, 1, 1);
      add_vec(1, 12'h000, 128, 0, 12'hF00, 1, 1, 1);
      add_vec(1, 12'h000, 224, 0, 12'hFFF, 1, 1, 1);
      add_vec(1, 12'h000, 255, 0, 12'hFFF, 1, 1, 1);
      add_vec(1, 12'h000,   0, 1, 12'h000, 1, 1, 1);
      add_vec(1, 12'h000,  40, 1, 12'h00F, 1, 1, 1);
      add_vec(3, 12'h000,   0, 0, 12'h000, 1, 1, 1);
      add_vec(3, 12'h000,  64, 0, 12'h111, 1, 1, 1);
      add_vec(3, 12'h000, 128, 0, 12'h222, 1, 1, 1);
      add_vec(3, 12'h000, 192, 0, 12'h333, 1, 1, 1);
      add_vec(3, 12'h000, 255, 0, 12'h333, 1, 1, 1);
      add_vec(2, 12'hFF0,   0, 0, 12'hFF0, 1, 1, 1);
      add_vec(2, 12'hFF0,  32, 0, 12'h00F, 1, 1, 1);
      add_vec(2, 12'hFF0,   0, 32, 12'h00F, 1, 1, 1);
      add_vec(2, 12'hFF0,  32, 32, 12'hFF0, 1, 1, 1);
      add_vec(2, 12'hFF0,  64, 32, 12'h00F, 1, 1, 1);
      add_vec(2, 12'hFF0,   0, 42, 12'h000, 1, 0, 0);
      add_vec(2, 12'hFF0,   0, 44, 12'h000, 1, 0, 0);
      add_vec(2, 12'hFF0,   0, 45, 12'h000, 1, 1, 0);

      #2;
      // First tick after release lands CLK_DIV clocks later and shows pixel (0,0).
      apply_stimulus(0, 12'h5A3, 10);
      n = 0;
      while (frame_start !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_val("first frame_start delay", 64'(n), 64'(CLK_DIV));
      check_val("first pixel position", 64'({pixel_x, pixel_y}), 64'(0));
      step();
      check_val("frame_start one clk", 64'(frame_start), 64'(0));

      cur_mode = -1;
      cur_color = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         target = vecs[i].y * H_TOTAL + vecs[i].x;
         if (vecs[i].mode != cur_mode || vecs[i].color != cur_color || tick_cnt > target) begin
            apply_stimulus(vecs[i].mode, vecs[i].color, 3);
            cur_mode  = vecs[i].mode;
            cur_color = vecs[i].color;
         end
         run_to(target);
         check_val($sformatf("vector %0d", i),
                   64'({rgb, hsync, vsync, video_on, pixel_x, pixel_y}),
                   64'({vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].von,
                        10'(vecs[i].x), 10'(vecs[i].y)}));
      end

      // Mid-frame input changes must wait for the next frame boundary.
      solid = RW'($urandom);
      apply_stimulus(0, solid, 4);
      rnd_on = 1'b1;
      run_to(10 * H_TOTAL);
      rnd_on = 1'b0;
      mode  = 2'd1;
      color = RW'($urandom);
      run_to(20 * H_TOTAL + 40);
      check_val("solid persists mid-frame", 64'(rgb), 64'(solid));
      run_to(FRAME + 40);
      check_val("bars after frame_start", 64'(rgb), 64'(12'h00F));
      rnd_on = 1'b1;
      run_to(FRAME + 6 * H_TOTAL + 50);
      rnd_on = 1'b0;

      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_val("async reset mid-frame",
                64'({frame_start, video_on, hsync, vsync, pixel_x, pixel_y, rgb}),
                64'({1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000}));
      check_output();
      mode  = 2'd1;
      color = RW'($urandom);
      @(negedge clk);
      reset = 1'b0;
      run_to(H_TOTAL + 40);
      check_val("bars after reset", 64'(rgb), 64'(12'h00F));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
